// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and a saturating bubble counter. Optional macro: ID_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic [3:0]        ex_alu_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  // A source operand matches a destination only if the instruction really reads it.
  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses & (rs == rd);
  endfunction

  logic              lu_s;
  logic [XLEN-1:0]   rs1_sel_s;
  logic [XLEN-1:0]   rs2_sel_s;

  logic              nxt_valid_s;
  logic [XLEN-1:0]   nxt_pc_s;
  logic [XLEN-1:0]   nxt_rs1_data_s;
  logic [XLEN-1:0]   nxt_rs2_data_s;
  logic [XLEN-1:0]   nxt_imm_s;
  logic [4:0]        nxt_rs1_addr_s;
  logic [4:0]        nxt_rs2_addr_s;
  logic [4:0]        nxt_rd_addr_s;
  logic              nxt_reg_write_s;
  logic              nxt_mem_read_s;
  logic              nxt_mem_write_s;
  logic              nxt_mem_to_reg_s;
  logic              nxt_alu_src_s;
  logic              nxt_branch_s;
  logic [3:0]        nxt_alu_ctrl_s;
  logic [CNT_W-1:0]  nxt_count_s;

  // Load-use detection against the load currently in EX; rd=x0 never hazards.
  always_comb begin
    lu_s = 1'b0;
    if (ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) && id_valid) begin
      lu_s = src_hit(id_uses_rs1, id_rs1_addr, ex_rd_addr) |
             src_hit(id_uses_rs2, id_rs2_addr, ex_rd_addr);
    end else begin
      lu_s = 1'b0;
    end
  end

  assign stall = lu_s & ~flush;

`ifdef ID_WB_BYPASS_EN
  logic rs1_byp_s;
  logic rs2_byp_s;
  assign rs1_byp_s = wb_reg_write & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs1_addr);
  assign rs2_byp_s = wb_reg_write & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs2_addr);
  assign rs1_sel_s = rs1_byp_s ? wb_data : id_rs1_data;
  assign rs2_sel_s = rs2_byp_s ? wb_data : id_rs2_data;
`else
  // Register file is write-through here, so the writeback port is not needed.
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_reg_write, wb_rd_addr, wb_data};
  assign rs1_sel_s   = id_rs1_data;
  assign rs2_sel_s   = id_rs2_data;
`endif

  // Next EX contents: bubble by default, loaded only for a clean valid instruction.
  always_comb begin
    nxt_valid_s      = 1'b0;
    nxt_pc_s         = {XLEN{1'b0}};
    nxt_rs1_data_s   = {XLEN{1'b0}};
    nxt_rs2_data_s   = {XLEN{1'b0}};
    nxt_imm_s        = {XLEN{1'b0}};
    nxt_rs1_addr_s   = 5'd0;
    nxt_rs2_addr_s   = 5'd0;
    nxt_rd_addr_s    = 5'd0;
    nxt_reg_write_s  = 1'b0;
    nxt_mem_read_s   = 1'b0;
    nxt_mem_write_s  = 1'b0;
    nxt_mem_to_reg_s = 1'b0;
    nxt_alu_src_s    = 1'b0;
    nxt_branch_s     = 1'b0;
    nxt_alu_ctrl_s   = 4'd0;
    nxt_count_s      = stall_count;
    if (flush) begin
      nxt_valid_s = 1'b0;
    end else if (lu_s) begin
      if (stall_count != {CNT_W{1'b1}}) begin
        nxt_count_s = stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        nxt_count_s = stall_count;
      end
    end else if (!id_valid) begin
      nxt_valid_s = 1'b0;
    end else begin
      nxt_valid_s      = 1'b1;
      nxt_pc_s         = id_pc;
      nxt_rs1_data_s   = rs1_sel_s;
      nxt_rs2_data_s   = rs2_sel_s;
      nxt_imm_s        = id_imm;
      nxt_rs1_addr_s   = id_rs1_addr;
      nxt_rs2_addr_s   = id_rs2_addr;
      nxt_rd_addr_s    = id_rd_addr;
      nxt_reg_write_s  = id_reg_write;
      nxt_mem_read_s   = id_mem_read;
      nxt_mem_write_s  = id_mem_write;
      nxt_mem_to_reg_s = id_mem_to_reg;
      nxt_alu_src_s    = id_alu_src;
      nxt_branch_s     = id_branch;
      nxt_alu_ctrl_s   = id_alu_ctrl;
    end
  end

  // Pipeline register and bubble counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= {XLEN{1'b0}};
      ex_rs1_data   <= {XLEN{1'b0}};
      ex_rs2_data   <= {XLEN{1'b0}};
      ex_imm        <= {XLEN{1'b0}};
      ex_rs1_addr   <= 5'd0;
      ex_rs2_addr   <= 5'd0;
      ex_rd_addr    <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_ctrl   <= 4'd0;
      stall_count   <= {CNT_W{1'b0}};
    end else begin
      ex_valid      <= nxt_valid_s;
      ex_pc         <= nxt_pc_s;
      ex_rs1_data   <= nxt_rs1_data_s;
      ex_rs2_data   <= nxt_rs2_data_s;
      ex_imm        <= nxt_imm_s;
      ex_rs1_addr   <= nxt_rs1_addr_s;
      ex_rs2_addr   <= nxt_rs2_addr_s;
      ex_rd_addr    <= nxt_rd_addr_s;
      ex_reg_write  <= nxt_reg_write_s;
      ex_mem_read   <= nxt_mem_read_s;
      ex_mem_write  <= nxt_mem_write_s;
      ex_mem_to_reg <= nxt_mem_to_reg_s;
      ex_alu_src    <= nxt_alu_src_s;
      ex_branch     <= nxt_branch_s;
      ex_alu_ctrl   <= nxt_alu_ctrl_s;
      stall_count   <= nxt_count_s;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural model,
// with directed load-use, flush, reset, bypass and saturation scenarios.
module tb_id_ex_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, flush;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write;
  logic id_mem_to_reg, id_alu_src, id_branch, wb_reg_write;
  logic [3:0] id_alu_ctrl;

  logic stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0] ex_alu_ctrl;
  logic [31:0] stall_count;

  logic s_stall, s_valid, s_rw, s_mr, s_mw, s_m2r, s_as, s_br;
  logic [XLEN-1:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0] s_rs1a, s_rs2a, s_rd;
  logic [3:0] s_ac, s_count;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_ctrl(id_alu_ctrl), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_alu_ctrl(ex_alu_ctrl), .stall_count(stall_count));

  id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_ctrl(id_alu_ctrl), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .flush(flush), .stall(s_stall), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs1_data(s_rs1d), .ex_rs2_data(s_rs2d), .ex_imm(s_imm),
    .ex_rs1_addr(s_rs1a), .ex_rs2_addr(s_rs2a), .ex_rd_addr(s_rd),
    .ex_reg_write(s_rw), .ex_mem_read(s_mr), .ex_mem_write(s_mw),
    .ex_mem_to_reg(s_m2r), .ex_alu_src(s_as), .ex_branch(s_br),
    .ex_alu_ctrl(s_ac), .stall_count(s_count));

  typedef struct packed {
    logic v; logic [XLEN-1:0] pc, rs1d, rs2d, imm; logic [4:0] rs1a, rs2a, rd;
    logic rw, mr, mw, m2r, as, br; logic [3:0] ac;
  } ex_t;

  ex_t dut_ex, sat_ex, m;
  logic [31:0] m_cnt;
  logic [3:0] m_cnt4;
  logic m_known = 1'b0;
  logic last_stall;
  int vectors = 0, miscompares = 0;

  assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
                   ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                   ex_branch, ex_alu_ctrl};
  assign sat_ex = {s_valid, s_pc, s_rs1d, s_rs2d, s_imm, s_rs1a, s_rs2a, s_rd, s_rw, s_mr, s_mw,
                   s_m2r, s_as, s_br, s_ac};

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the ID instruction must wait if it reads a register a valid EX load is producing.
  function automatic logic model_lu();
    if (!m.v || !m.mr || m.rd == 5'd0 || !id_valid) return 1'b0;
    return (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] a, input logic [XLEN-1:0] d);
`ifdef ID_WB_BYPASS_EN
    if (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == a) return wb_data;
`endif
    return d;
  endfunction

  // One clock: check comb stall, advance the model across the edge, check registered outputs.
  task automatic cycle();
    ex_t nm;
    logic [31:0] nc;
    logic [3:0] nc4;
    logic lu;
    #1;
    lu = model_lu();
    last_stall = stall;
    if (m_known) begin
      chk("stall", stall, lu & ~flush);
      chk("sat_stall", s_stall, lu & ~flush);
    end
    nm = '0; nc = m_cnt; nc4 = m_cnt4;
    if (rst) begin nc = 32'd0; nc4 = 4'd0; end
    else if (flush) nm = '0;
    else if (lu) begin
      if (nc != 32'hFFFF_FFFF) nc = nc + 32'd1;
      if (nc4 != 4'd15) nc4 = nc4 + 4'd1;
    end
    else if (!id_valid) nm = '0;
    else nm = '{v: 1'b1, pc: id_pc, rs1d: operand(id_rs1_addr, id_rs1_data),
                rs2d: operand(id_rs2_addr, id_rs2_data), imm: id_imm, rs1a: id_rs1_addr,
                rs2a: id_rs2_addr, rd: id_rd_addr, rw: id_reg_write, mr: id_mem_read,
                mw: id_mem_write, m2r: id_mem_to_reg, as: id_alu_src, br: id_branch, ac: id_alu_ctrl};
    if (!m_known && !rst) nm = 'x;
    @(posedge clk);
    m = nm; m_cnt = nc; m_cnt4 = nc4;
    if (rst) m_known = 1'b1;
    #1;
    if (m_known) begin
      chk("ex", dut_ex, m);
      chk("sat_ex", sat_ex, m);
      chk("count", stall_count, m_cnt);
      chk("sat_count", s_count, m_cnt4);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic mr);
    id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mr; id_reg_write = 1'b1;
    id_mem_to_reg = mr; id_mem_write = 1'b0; id_alu_src = mr; id_branch = 1'b0;
    id_alu_ctrl = 4'b0000; id_pc = 64'h200; id_imm = 64'h8;
    id_rs1_data = 64'h11; id_rs2_data = 64'h22;
  endtask

  task automatic randomize_id();
    id_valid = ($urandom_range(0, 7) != 0);
    id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
    id_rd_addr = 5'($urandom_range(0, 7));
    id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
    id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
    id_mem_write = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
    id_alu_src = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
    id_alu_ctrl = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_data = 64'd0;
    m = '0; m_cnt = 32'd0; m_cnt4 = 4'd0;
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
    cycle(); cycle();
    chk("reset_ex", dut_ex, '0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_count", stall_count, 32'd0);
    rst = 1'b0;

    // Pass-through
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0);
    id_pc = 64'h100; id_alu_ctrl = 4'b1000;
    cycle();
    chk("pass_valid", ex_valid, 1'b1);
    chk("pass_pc", ex_pc, 64'h100);
    chk("pass_rd", ex_rd_addr, 5'd7);
    chk("pass_alu", ex_alu_ctrl, 4'b1000);

    // Load-use: ld x5 then add x7,x5,x6
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0); cycle();
    chk("lu_stall", last_stall, 1'b1);
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_count", stall_count, 32'd1);
    cycle();
    chk("lu_release_stall", last_stall, 1'b0);
    chk("lu_enter_rd", {ex_valid, ex_rd_addr}, {1'b1, 5'd7});

    // Load to x0 never stalls
    set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd0, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0); cycle();
    chk("x0_stall", last_stall, 1'b0);
    chk("x0_valid", ex_valid, 1'b1);

    // I-type: rs2 field matches but is not read
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0); cycle();
    chk("itype_stall", last_stall, 1'b0);
    chk("itype_valid", ex_valid, 1'b1);

    // Flush together with load-use
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0); flush = 1'b1; cycle();
    flush = 1'b0;
    chk("flush_stall", last_stall, 1'b0);
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_count", stall_count, 32'd1);

    // Reset in the middle of a stall
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0); rst = 1'b1; cycle();
    rst = 1'b0;
    chk("rst_mid_bubble", dut_ex, '0);
    cycle();
    chk("rst_mid_stall", last_stall, 1'b0);
    chk("rst_mid_count", stall_count, 32'd0);

    // Writeback bypass
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0);
    id_rs1_data = 64'h1; wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_data = 64'hDEAD; cycle();
`ifdef ID_WB_BYPASS_EN
    chk("bypass_hit", ex_rs1_data, 64'hDEAD);
`else
    chk("bypass_off", ex_rs1_data, 64'h1);
`endif
    wb_rd_addr = 5'd0; cycle();
    chk("bypass_x0", ex_rs1_data, 64'h1);
    wb_reg_write = 1'b0;

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); cycle();
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0); cycle(); cycle();
    end
    chk("sat_hold", s_count, 4'd15);
    chk("wide_count", stall_count, 32'd20);

    // Random traffic; a stalled instruction is usually held in ID as IF/ID would
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall || $urandom_range(0, 9) == 0) randomize_id();
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 11) == 0);
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_rd_addr = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV64 core: it registers decoded ID-stage operands and control into the EX stage, detects load-use hazards, and inserts bubbles. Its `ex_rs1_addr`, `ex_rs2_addr`, `ex_reg_write` and related outputs are the EX-side inputs of the forwarding unit. It also drives the stall to the PC and IF/ID registers, and applies branch flushes.

## Interface
- `XLEN`, 64, datapath width
- `CNT_W`, 32, stall-counter width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_pc` in XLEN: PC of the ID instruction
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data
- `id_imm` in XLEN: sign-extended immediate
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5: register addresses
- `id_uses_rs1`, `id_uses_rs2` in 1: the instruction actually reads rs1 / rs2
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src`, `id_branch` in 1: decoded control
- `id_alu_ctrl` in 4: {instr[30], funct3}
- `wb_reg_write` in 1, `wb_rd_addr` in 5, `wb_data` in XLEN: writeback port (used by the bypass)
- `flush` in 1: branch taken in EX; squash the ID instruction
- `stall` out 1: hold PC and IF/ID this cycle
- `ex_valid` out 1, `ex_pc`/`ex_rs1_data`/`ex_rs2_data`/`ex_imm` out XLEN
- `ex_rs1_addr`/`ex_rs2_addr`/`ex_rd_addr` out 5
- `ex_reg_write`/`ex_mem_read`/`ex_mem_write`/`ex_mem_to_reg`/`ex_alu_src`/`ex_branch` out 1, `ex_alu_ctrl` out 4
- `stall_count` out CNT_W: saturating count of load-use bubbles

## Operation
- Load-use hazard, combinational: `lu = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & ((id_uses_rs1 & id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & id_rs2_addr == ex_rd_addr))`.
- `stall = lu & ~flush`.
- Next-state selection per edge, in priority order:
  - `rst`: bubble; `stall_count` is cleared.
  - `flush`: bubble.
  - `lu`: bubble; `stall_count` increments.
  - `~id_valid`: bubble.
  - Otherwise: load all `ex_*` from `id_*` and set `ex_valid=1`.
- Bubble: `ex_valid=0`, all control bits 0, `ex_alu_ctrl=0`, all addresses 0 (so the forwarding unit sees rd=x0), all data fields 0.
- Under a stall, IF/ID holds the same instruction. The next cycle the EX bubble has `ex_mem_read=0`, so `lu` drops and the held instruction enters EX. Exactly one bubble is inserted per load-use.
- `stall_count` saturates at all-ones and never wraps. Flushes and `~id_valid` bubbles do not count.
- x0: `id_rd_addr=0` is registered unchanged. The hazard check ignores `ex_rd_addr=0`.

## Timing
- One-cycle latency from ID inputs to `ex_*` outputs.
- `stall` is combinational, valid in the same cycle as the ID inputs; no internal path from `stall` back to `lu`.
- Reset: every output is 0, including `stall` (because `ex_valid=0`) and `stall_count`.
- Reset asserted mid-stall: the next edge produces a bubble, and `stall` is 0 in the following cycle.
- `flush` together with `lu`: `stall=0`, a bubble is inserted, and the counter does not increment.
- Back-to-back loads with a dependency: each dependent pair costs exactly one bubble.

## Configuration
- `ID_WB_BYPASS_EN` defined: each source operand is bypassed independently when `wb_reg_write & wb_rd_addr != 0 & wb_rd_addr == id_rsN_addr`. In that case `ex_rsN_data` latches `wb_data` instead of `id_rsN_data`. This covers a register file without write-before-read.
- `ID_WB_BYPASS_EN` undefined: `id_rsN_data` is always latched. The register file must provide write-through.

## Test plan
- Reset: hold `rst` 2 cycles with ID valid -> all `ex_*`=0, `stall`=0, `stall_count`=0.
- Pass-through: `id_pc=0x100`, `rs1=5`, `rs2=6`, `rd=7`, `reg_write=1`, `alu_ctrl=4'b1000` -> after one edge `ex_*` match and `ex_valid=1`.
- Load-use: EX holds `ld x5` (`mem_read=1`, `rd=5`); ID holds `add x7,x5,x6` with `uses_rs1=1` -> `stall=1` for one cycle, one bubble, add enters EX next, `stall_count=1`.
  - Same setup with `rd=0` -> no stall.
  - Same setup with `uses_rs2=0` and `rs2=5` (I-type) -> no stall.
- Flush with a simultaneous load-use -> `stall=0`, `ex_valid=0` next cycle, `stall_count` unchanged.
- With `ID_WB_BYPASS_EN`: `wb_rd=5`, `wb_data=0xDEAD`, `id_rs1_addr=5`, `id_rs1_data=0x1` -> `ex_rs1_data=0xDEAD`.
  - Same setup with `wb_rd=0` -> `ex_rs1_data=0x1`.
  - Without the macro -> `ex_rs1_data=0x1`.
- Saturation: preload via a `CNT_W=4` instance, then 20 load-use events -> `stall_count` stays at 15.
